// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  localparam int DEF_AW        = 32;
  localparam int DEF_DW        = 32;
  localparam int DEF_MEM_WORDS = 1024;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

  localparam logic PORT_MEM = 1'b0;
  localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner select for the two requesters. DMEM_ARB_RR_EN selects round-robin with a
// last-granted pointer; otherwise port 0 has fixed priority and no pointer exists.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic advance,
  output logic grant_valid,
  output logic grant_id
);

  assign grant_valid = req0 | req1;

`ifdef DMEM_ARB_RR_EN
  logic last_id;

  // Pointer holds the port granted most recently; on contention the other one wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_id <= PORT_MEM;
    else if (advance && grant_valid)
      last_id <= grant_id;
  end

  always_comb begin
    grant_id = PORT_MEM;
    if (req0 && req1)
      grant_id = ~last_id;
    else if (req1)
      grant_id = PORT_AUX;
  end
`else
  logic unused_pick;
  assign unused_pick = &{1'b0, clk, reset, advance};
  assign grant_id    = req0 ? PORT_MEM : PORT_AUX;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port combinational data memory between the pipeline MEM stage
// (port 0) and a loader/debug master (port 1). Optional macro: DMEM_ARB_RR_EN.
//   state  | meaning
//   IDLE   | no access in flight, waiting for a request
//   ACCESS | strobes and gnt driven for the latched request (one cycle)
//   DONE   | rvalid for the owner; a pending request goes straight to ACCESS
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int MEM_WORDS = DEF_MEM_WORDS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  output logic          err0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          err1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  state_t        state;
  logic          owner;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  logic          grant_valid;
  logic          grant_id;
  logic          advance;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_in_range;
  logic          lat_in_range;
  logic [DW-1:0] acc_rdata;

  // Arbitration only matters where a new access may start.
  assign advance = (state != ACCESS);

  dmem_arb_pick u_pick (
    .clk         (clk),
    .reset       (reset),
    .req0        (req0),
    .req1        (req1),
    .advance     (advance),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign sel_we       = (grant_id == PORT_AUX) ? we1    : we0;
  assign sel_addr     = (grant_id == PORT_AUX) ? addr1  : addr0;
  assign sel_wdata    = (grant_id == PORT_AUX) ? wdata1 : wdata0;
  assign sel_in_range = sel_addr < AW'(MEM_WORDS);
  assign lat_in_range = addr_q < AW'(MEM_WORDS);
  assign acc_rdata    = (!we_q && lat_in_range) ? mem_rdata : '0;

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= PORT_MEM;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      busy      <= 1'b0;
    end else begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (grant_valid) begin
            owner     <= grant_id;
            we_q      <= sel_we;
            addr_q    <= sel_addr;
            wdata_q   <= sel_wdata;
            gnt0      <= (grant_id == PORT_MEM);
            gnt1      <= (grant_id == PORT_AUX);
            mem_read  <= !sel_we && sel_in_range;
            mem_write <= sel_we && sel_in_range;
            state     <= ACCESS;
            busy      <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        ACCESS: begin
          if (owner == PORT_AUX) begin
            rdata1  <= acc_rdata;
            err1    <= !lat_in_range;
            rvalid1 <= 1'b1;
          end else begin
            rdata0  <= acc_rdata;
            err0    <= !lat_in_range;
            rvalid0 <= 1'b1;
          end
          state <= DONE;
          busy  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural memory, per-port scoreboards
// popped on rvalid, and directed timing checks around each access.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, rvalid0, err0, gnt1, rvalid1, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, busy;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } sb_t;

  sb_t         q0[$];
  sb_t         q1[$];
  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] last0;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input int a);
    return (a == 100) ? 32'd9 : (32'hC0DE_0000 | 32'(a));
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model: preloaded, written mid-cycle while the write strobe is high.
  assign mem_rdata = (mem_addr < 32'd1024) ? mem[mem_addr[9:0]] : 32'h0;
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = pat(i);
    forever begin
      @(negedge clk);
      if (mem_write && mem_addr < 32'd1024) mem[mem_addr[9:0]] = mem_wdata;
    end
  end

  // Scoreboard: pop one expectation per completion; a port 1 completion leaves rdata0 alone.
  always @(negedge clk) begin
    sb_t e;
    if (reset) last0 = 32'h0;
    if (rvalid0) begin
      if (q0.size() == 0) chk("sb0_unexpected", 1, 0);
      else begin
        e = q0.pop_front();
        chk("rdata0", rdata0, e.rdata);
        chk("err0", err0, e.err);
        last0 = e.rdata;
      end
    end
    if (rvalid1) begin
      if (q1.size() == 0) chk("sb1_unexpected", 1, 0);
      else begin
        e = q1.pop_front();
        chk("rdata1", rdata1, e.rdata);
        chk("err1", err1, e.err);
        chk("rdata0_hold", rdata0, last0);
      end
    end
  end

  task automatic drive(input logic p, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (p) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
  endtask

  task automatic expect_acc(input logic p, input logic w, input logic [31:0] a,
                            input logic [31:0] d);
    sb_t e;
    logic ir;
    ir = a < 32'd1024;
    if (w && ir) ref_mem[a[9:0]] = d;
    e.rdata = (!w && ir) ? ref_mem[a[9:0]] : 32'h0;
    e.err   = !ir;
    if (p) q1.push_back(e); else q0.push_back(e);
  endtask

  task automatic do_access(input logic p, input logic w, input logic [31:0] a,
                           input logic [31:0] d);
    logic ir;
    ir = a < 32'd1024;
    expect_acc(p, w, a, d);
    @(posedge clk); #1;
    drive(p, 1'b1, w, a, d);
    @(posedge clk); @(negedge clk);
    chk("gnt", p ? gnt1 : gnt0, 1);
    chk("gnt_other", p ? gnt0 : gnt1, 0);
    chk("rd_strobe", mem_read, !w && ir);
    chk("wr_strobe", mem_write, w && ir);
    if (ir) chk("mem_addr", mem_addr, a);
    if (w && ir) chk("mem_wdata", mem_wdata, d);
    @(posedge clk); #1;
    drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rvalid", p ? rvalid1 : rvalid0, 1);
    chk("done_strobe", {mem_read, mem_write}, 0);
    chk("done_busy", busy, 1);
    @(posedge clk); @(negedge clk);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   gcyc;
    logic first;
    gcyc = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", {gnt0, gnt1}, 0);
    chk("rst_rvalid", {rvalid0, rvalid1}, 0);
    chk("rst_rdata", {rdata0, rdata1}, 0);
    chk("rst_err", {err0, err1}, 0);
    chk("rst_strobe", {mem_read, mem_write}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_addr", mem_addr, 0);
    reset = 1'b0;

    // Write then read back through port 0, then port 1 reads preloaded 9.
    do_access(1'b0, 1'b1, 32'd8, 32'hA5);
    do_access(1'b0, 1'b0, 32'd8, 32'h0);
    do_access(1'b1, 1'b0, 32'd100, 32'h0);
    do_access(1'b1, 1'b1, 32'd200, 32'h1234_5678);
    do_access(1'b1, 1'b0, 32'd200, 32'h0);

    // Out-of-range: no strobes, err set, rdata zero.
    do_access(1'b0, 1'b0, 32'd1024, 32'h0);
    do_access(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hDEAD);

    // Reset during the ACCESS cycle of a write.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 32'd20, 32'h7777);
    @(posedge clk); #1;
    chk("rst_pre_wr", mem_write, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_wr", mem_write, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_gnt", gnt0, 0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_no_rvalid", rvalid0, 0);
    do_access(1'b0, 1'b0, 32'd8, 32'h0);

    // Contention from a freshly reset arbiter.
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
`ifdef DMEM_ARB_RR_EN
    first = 1'b1;
`else
    first = 1'b0;
`endif
    expect_acc(1'b0, 1'b0, 32'd30, 32'h0);
    expect_acc(1'b1, 1'b0, 32'd31, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'd30, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'd31, 32'h0);
    @(posedge clk); @(negedge clk);
    chk("cont_first_gnt0", gnt0, !first);
    chk("cont_first_gnt1", gnt1, first);
    @(posedge clk); #1;
    drive(first, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("cont_first_rv", first ? rvalid1 : rvalid0, 1);
    @(posedge clk); @(negedge clk);
    chk("cont_second_gnt", first ? gnt0 : gnt1, 1);
    chk("cont_no_idle", busy, 1);
    @(posedge clk); #1;
    drive(!first, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("cont_second_rv", first ? rvalid0 : rvalid1, 1);
    @(posedge clk); @(negedge clk);
    chk("cont_idle", busy, 0);

    // Four back-to-back port 0 reads with req held high.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 32'd40, 32'h0);
    expect_acc(1'b0, 1'b0, 32'd40, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
      chk("stream_gnt", gnt0, 1);
      if (k > 0) chk("stream_period", 64'(cyc - gcyc), 2);
      gcyc = cyc;
      @(posedge clk); #1;
      if (k < 3) begin
        addr0 = 32'd41 + 32'(k);
        expect_acc(1'b0, 1'b0, addr0, 32'h0);
      end else begin
        req0 = 1'b0;
      end
      @(negedge clk);
      chk("stream_busy", busy, 1);
      chk("stream_rv", rvalid0, 1);
    end
    @(posedge clk); @(negedge clk);
    chk("stream_busy_drop", busy, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb0_drain", 64'(q0.size()), 0);
    chk("sb1_drain", 64'(q1.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
